// File: rtl/mips_pkg.sv
// Shared MIPS branch-encoding definitions: default offset width, next-PC increment,
// word type and the sign-consistency helper used to judge offset range.
package mips_pkg;

    localparam int          IMM_W_DEF  = 16;
    localparam logic [31:0] PC_INC_DEF = 32'd4;
    localparam int          ERR_CNT_W  = 8;

    typedef logic [31:0] word_t;

    // True when every bit from position lsb up to bit 31 matches bit 31,
    // i.e. the value survives truncation to lsb+1 signed bits.
    function automatic logic hi_bits_uniform(input word_t w, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb && w[i] != w[31]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/boe_pipe_reg.sv
// Generic valid/ready register slice; accepts whenever empty or draining this cycle,
// holds its payload stable while stalled.
module boe_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/branch_offset_encoder.sv
// Encodes (branch PC, byte target) into the signed word offset of a MIPS I-type branch.
// Optional error counter (err_clr / err_cnt ports) is enabled by defining BOE_ERR_CNT_EN.
module branch_offset_encoder
    import mips_pkg::*;
#(
    parameter int    IMM_W  = IMM_W_DEF,
    parameter word_t PC_INC = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic [31:0]      out_imm_ext,
    output logic             out_misalign,
    output logic             out_range
`ifdef BOE_ERR_CNT_EN
    ,
    input  logic             err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int S1_W = 64;
    localparam int S2_W = IMM_W + 2;

    logic [S1_W-1:0]  s1_data;
    logic             s1_valid;
    logic             s2_in_ready;
    word_t            s1_pc;
    word_t            s1_target;
    word_t            diff;
    logic [IMM_W-1:0] enc_imm;
    logic             enc_mis;
    logic             enc_rng;
    logic [S2_W-1:0]  s2_data;

    boe_pipe_reg #(.W(S1_W)) u_s1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({in_pc, in_target}),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready),
        .out_data_o  (s1_data)
    );

    assign {s1_pc, s1_target} = s1_data;

    // Offset is relative to the delay-slot address; modular arithmetic handles wrap-around.
    assign diff    = s1_target - (s1_pc + PC_INC);
    assign enc_imm = diff[IMM_W+1:2];
    assign enc_rng = !hi_bits_uniform(diff, IMM_W + 1);
    assign enc_mis = (|s1_pc[1:0]) | (|s1_target[1:0]);

    boe_pipe_reg #(.W(S2_W)) u_s2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .in_data_i   ({enc_mis, enc_rng, enc_imm}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_data)
    );

    assign {out_misalign, out_range, out_imm} = s2_data;
    assign out_imm_ext = {{(32-IMM_W){out_imm[IMM_W-1]}}, out_imm};

`ifdef BOE_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_fire;

    assign err_fire = out_valid && out_ready && (out_misalign || out_range);

    // Clear takes priority over a coincident error; count saturates instead of wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_fire && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Directed and randomized-property bench for branch_offset_encoder; error-counter
// checks are compiled in when BOE_ERR_CNT_EN is defined.
module tb_branch_offset_encoder;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic [15:0] imm;
        logic        mis;
        logic        rng;
        bit          rt;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [31:0] out_imm_ext;
    logic        out_misalign;
    logic        out_range;
`ifdef BOE_ERR_CNT_EN
    logic        err_clr;
    logic [7:0]  err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;
    req_t send_q[$];
    req_t exp_q[$];

    always #5 clk = ~clk;

    branch_offset_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_target    (in_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_imm_ext  (out_imm_ext),
        .out_misalign (out_misalign),
        .out_range    (out_range)
`ifdef BOE_ERR_CNT_EN
        ,
        .err_clr      (err_clr),
        .err_cnt      (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic req_t mk(input logic [31:0] pc, input logic [31:0] tg,
                                input logic [15:0] imm, input logic mis, input logic rng);
        req_t r;
        r.pc = pc; r.target = tg; r.imm = imm; r.mis = mis; r.rng = rng; r.rt = 1'b0;
        return r;
    endfunction

    function automatic req_t mk_rand();
        req_t r;
        int   soff;
        soff     = int'($urandom_range(0, 65535)) - 32768;
        r.pc     = $urandom & 32'hFFFF_FFFC;
        r.target = r.pc + 32'd4 + (soff * 4);
        r.imm = '0; r.mis = 1'b0; r.rng = 1'b0; r.rt = 1'b1;
        return r;
    endfunction

    // One clock: drive the head of send_q, then account for transfers on the coming edge.
    task automatic run_cycle(input bit ordy);
        req_t r;
        bit   acc, emit;
        @(negedge clk);
        out_ready = ordy;
        if (send_q.size() > 0) begin
            in_valid  = 1'b1;
            in_pc     = send_q[0].pc;
            in_target = send_q[0].target;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (emit) begin
            out_count++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out observed=out_valid expected=no_output imm=%h", out_imm);
            end
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                $display("OUT %0d pc=%h target=%h imm=%h ext=%h mis=%0b rng=%0b",
                         out_count, r.pc, r.target, out_imm, out_imm_ext, out_misalign, out_range);
                if (r.rt) begin
                    chk("roundtrip", (out_imm_ext << 2) + r.pc + 32'd4, r.target);
                    chk("rt_range", out_range, 1'b0);
                    chk("rt_misalign", out_misalign, 1'b0);
                end else begin
                    chk("imm", out_imm, r.imm);
                    chk("imm_ext", out_imm_ext, {{16{r.imm[15]}}, r.imm});
                    chk("misalign", out_misalign, r.mis);
                    chk("range", out_range, r.rng);
                end
            end
        end
        if (acc) begin
            exp_q.push_back(send_q.pop_front());
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((send_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
            run_cycle(1'b1);
            n++;
        end
        chk("drain_pending", send_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        int   cycles;
        int   base;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_target = '0;
`ifdef BOE_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_imm", out_imm, 16'h0000);
        chk("rst_out_imm_ext", out_imm_ext, 32'h0);
        chk("rst_misalign", out_misalign, 1'b0);
        chk("rst_range", out_range, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Test 1 with explicit latency: accept edge, one empty cycle, then valid.
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h0000_0100; in_target = 32'h0000_0120; out_ready = 1'b1;
        #1;
        chk("t1_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t1_valid_early", out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("t1_valid_lat2", out_valid, 1'b1);
        chk("t1_imm", out_imm, 16'h0007);
        chk("t1_misalign", out_misalign, 1'b0);
        chk("t1_range", out_range, 1'b0);
        @(negedge clk);
        #1;
        chk("t1_drained", out_valid, 1'b0);

        // Directed encodings: sign, range boundaries, misalignment, wrap-around.
        send_q.push_back(mk(32'h0000_0100, 32'h0000_00F0, 16'hFFFB, 1'b0, 1'b0));
        send_q.push_back(mk(32'h0000_0000, 32'h0002_0000, 16'h7FFF, 1'b0, 1'b0));
        send_q.push_back(mk(32'h0000_0000, 32'h0002_0004, 16'h8000, 1'b0, 1'b1));
        send_q.push_back(mk(32'h0002_0000, 32'h0000_0004, 16'h8000, 1'b0, 1'b0));
        send_q.push_back(mk(32'h0002_0000, 32'h0000_0000, 16'h7FFF, 1'b0, 1'b1));
        send_q.push_back(mk(32'h0000_0100, 32'h0000_0122, 16'h0007, 1'b1, 1'b0));
        send_q.push_back(mk(32'h0000_0101, 32'h4000_0000, 16'hFFBE, 1'b1, 1'b1));
        send_q.push_back(mk(32'hFFFF_FFFC, 32'h0000_0008, 16'h0002, 1'b0, 1'b0));
        send_q.push_back(mk(32'h0000_0004, 32'hFFFF_FFF0, 16'hFFFA, 1'b0, 1'b0));
        drain(100);

        // Random in-range aligned pairs at full rate: 1000 requests, 2-cycle pipeline fill.
        for (int i = 0; i < 1000; i++) begin
            send_q.push_back(mk_rand());
        end
        cycles = 0;
        while ((send_q.size() != 0 || exp_q.size() != 0) && cycles < 3000) begin
            run_cycle(1'b1);
            cycles++;
        end
        chk("full_rate_cycles", cycles, 1002);

        // Backpressure: 8 back-to-back requests with the consumer stalled for 5 cycles.
        for (int i = 0; i < 8; i++) begin
            send_q.push_back(mk_rand());
        end
        base = out_count;
        repeat (5) run_cycle(1'b0);
        chk("bp_held", exp_q.size(), 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        drain(100);
        chk("bp_outputs", out_count - base, 8);

        // Reset in the middle of a stream discards everything in flight.
        for (int i = 0; i < 6; i++) begin
            send_q.push_back(mk_rand());
        end
        repeat (4) run_cycle(1'b1);
        chk("mid_valid_before", out_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_imm", out_imm, 16'h0000);
        send_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        base = out_count;
        repeat (6) run_cycle(1'b1);
        chk("mid_no_output", out_count - base, 0);

`ifdef BOE_ERR_CNT_EN
        // 300 misaligned requests saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            send_q.push_back(mk(32'h0000_0100, 32'h0000_0101, 16'hFFFF, 1'b1, 1'b0));
        end
        drain(1000);
        chk("err_sat", err_cnt, 8'd255);
        send_q.push_back(mk(32'h0000_0100, 32'h0000_0101, 16'hFFFF, 1'b1, 1'b0));
        repeat (2) run_cycle(1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        err_clr = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("err_clr_has_error", out_valid && out_misalign, 1'b1);
        chk("err_before_clr", err_cnt, 8'd255);
        @(negedge clk);
        err_clr = 1'b0;
        void'(exp_q.pop_front());
        #1;
        chk("err_clr_wins", err_cnt, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
